// File: rtl/acc16_prog_loader_pkg.sv
// acc16_prog_loader_pkg
//   Shared constants for the acc16 program/data loader.
//   This package holds the default memory geometry, the record start byte,
//   the REGION codes and the loader FSM state encodings (4-bit).
//   It also provides a helper that decides whether a word address lies
//   inside the selected memory.
package acc16_prog_loader_pkg;

   typedef logic [7:0] byte_t;

   localparam int    DEF_L_INS = 401;
   localparam int    DEF_L_TOT = 1024;
   localparam byte_t DEF_MAGIC = 8'hA5;

   localparam byte_t REG_INS  = 8'h00;
   localparam byte_t REG_DATA = 8'h01;
   localparam byte_t REG_RUN  = 8'h02;

   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_REGION = 4'd1;
   localparam logic [3:0] ST_ADDR_H = 4'd2;
   localparam logic [3:0] ST_ADDR_L = 4'd3;
   localparam logic [3:0] ST_CNT_H  = 4'd4;
   localparam logic [3:0] ST_CNT_L  = 4'd5;
   localparam logic [3:0] ST_DATA_H = 4'd6;
   localparam logic [3:0] ST_DATA_L = 4'd7;
   localparam logic [3:0] ST_CSUM   = 4'd8;

   // True when a full 16-bit record address falls inside a memory of 'depth' words.
   // Any address with bits [15:10] set is always outside, because depth <= 1024.
   function automatic logic addr_in_range(input logic [15:0] addr, input logic [15:0] depth);
      return (addr < depth);
   endfunction

endpackage

// File: rtl/acc16_prog_loader_if.sv
// acc16_prog_loader_if
//   Valid/ready byte stream from the host bridge into the loader.
//   Signals:
//     in_valid  source -> loader   byte present on in_data
//     in_data   source -> loader   stream byte
//     in_ready  loader -> source   byte taken when in_valid & in_ready
//   Modports: master = byte source, slave = loader.
interface acc16_prog_loader_if;
   import acc16_prog_loader_pkg::*;

   logic  in_valid;
   byte_t in_data;
   logic  in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/acc16_prog_loader.sv
// acc16_prog_loader
//   Byte-stream program/data loader for the 16-bit accumulator core.
//   Parses records  MAGIC REGION ADDR_H ADDR_L CNT_H CNT_L {DATA_H DATA_L}xCNT CSUM.
//   It assembles big-endian words and writes them into the instruction memory
//   (L_INS words) or the data memory (L_TOT-L_INS words).
//   A RUN record (REGION=02) releases the core hold.
//   Ports:
//     clk1       sole clock
//     rst        asynchronous active-low reset
//     in_bus     byte stream (slave side): in_valid, in_data, in_ready
//     mem_we     one-cycle write strobe
//     mem_sel    0 = instruction memory, 1 = data memory
//     mem_addr   word address within the selected memory
//     mem_wdata  word to write
//     cpu_hold   1 = core held halted
//     done       one-cycle pulse on a good checksum or an accepted RUN
//     err        sticky checksum/region/range error, cleared by the next MAGIC
//     words_wr   real writes since reset, saturating at 2047
module acc16_prog_loader
   import acc16_prog_loader_pkg::*;
#(
   parameter int    L_INS = DEF_L_INS,
   parameter int    L_TOT = DEF_L_TOT,
   parameter byte_t MAGIC = DEF_MAGIC
) (
   input  logic                       clk1,
   input  logic                       rst,
   acc16_prog_loader_if.slave         in_bus,
   output logic                       mem_we,
   output logic                       mem_sel,
   output logic [9:0]                 mem_addr,
   output logic [15:0]                mem_wdata,
   output logic                       cpu_hold,
   output logic                       done,
   output logic                       err,
   output logic [10:0]                words_wr
);

   localparam logic [15:0] DEPTH_INS  = 16'(L_INS);
   localparam logic [15:0] DEPTH_DATA = 16'(L_TOT - L_INS);

   function automatic logic [10:0] sat_inc11(input logic [10:0] v);
      return (v == 11'h7FF) ? v : v + 11'd1;
   endfunction

   logic [3:0]  state;
   logic [15:0] addr;
   logic [15:0] cnt;
   byte_t       csum;
   byte_t       data_h;
   logic        ready_q;

   logic        take;
   byte_t       b;
   logic [15:0] depth;
   logic        wr_ok;

   assign in_bus.in_ready = ready_q;
   assign take  = in_bus.in_valid & ready_q;
   assign b     = in_bus.in_data;
   assign depth = mem_sel ? DEPTH_DATA : DEPTH_INS;
   assign wr_ok = addr_in_range(addr, depth);

   always_ff @(posedge clk1 or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         addr      <= '0;
         cnt       <= '0;
         csum      <= '0;
         data_h    <= '0;
         ready_q   <= 1'b0;
         mem_we    <= 1'b0;
         mem_sel   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_hold  <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
         words_wr  <= '0;
      end else begin
         ready_q <= 1'b1;
         mem_we  <= 1'b0;
         done    <= 1'b0;
         if (take) begin
            case (state)
               ST_IDLE: begin
                  // Only IDLE recognises MAGIC; every other byte here is line noise.
                  if (b == MAGIC) begin
                     err      <= 1'b0;
                     csum     <= '0;
                     cpu_hold <= 1'b1;
                     state    <= ST_REGION;
                  end
               end
               ST_REGION: begin
                  csum <= csum ^ b;
                  case (b)
                     REG_INS: begin
                        mem_sel <= 1'b0;
                        state   <= ST_ADDR_H;
                     end
                     REG_DATA: begin
                        mem_sel <= 1'b1;
                        state   <= ST_ADDR_H;
                     end
                     REG_RUN: begin
                        cpu_hold <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_IDLE;
                     end
                     default: begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                     end
                  endcase
               end
               ST_ADDR_H: begin
                  csum        <= csum ^ b;
                  addr[15:8]  <= b;
                  state       <= ST_ADDR_L;
               end
               ST_ADDR_L: begin
                  csum       <= csum ^ b;
                  addr[7:0]  <= b;
                  // Address bits above the 10-bit word space are a range error.
                  if (addr[15:10] != 6'd0) err <= 1'b1;
                  state      <= ST_CNT_H;
               end
               ST_CNT_H: begin
                  csum       <= csum ^ b;
                  cnt[15:8]  <= b;
                  state      <= ST_CNT_L;
               end
               ST_CNT_L: begin
                  csum       <= csum ^ b;
                  cnt[7:0]   <= b;
                  state      <= ({cnt[15:8], b} == 16'd0) ? ST_CSUM : ST_DATA_H;
               end
               ST_DATA_H: begin
                  csum   <= csum ^ b;
                  data_h <= b;
                  state  <= ST_DATA_L;
               end
               ST_DATA_L: begin
                  csum <= csum ^ b;
                  if (wr_ok) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= addr[9:0];
                     mem_wdata <= {data_h, b};
                     words_wr  <= sat_inc11(words_wr);
                  end else begin
                     err <= 1'b1;
                  end
                  // Hold at the top instead of wrapping so an overrun can never land at word 0.
                  addr  <= (addr == 16'hFFFF) ? addr : addr + 16'd1;
                  cnt   <= cnt - 16'd1;
                  state <= (cnt == 16'd1) ? ST_CSUM : ST_DATA_H;
               end
               ST_CSUM: begin
                  if (b == csum) done <= 1'b1;
                  else           err  <= 1'b1;
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_acc16_prog_loader.sv
// tb_acc16_prog_loader
//   Directed bench for acc16_prog_loader: reset values, instruction load,
//   data load and RUN, bad checksum, region error, range suppression, gapped
//   stream with leading garbage, reset in the middle of a record, and a CNT=0
//   record.
module tb_acc16_prog_loader;

   logic        clk1 = 1'b0;
   logic        rst  = 1'b0;
   logic        mem_we;
   logic        mem_sel;
   logic [9:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        err;
   logic [10:0] words_wr;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] wlog[$];
   logic [7:0]  txq[$];
   int          wbase;

   acc16_prog_loader_if lp_if ();

   acc16_prog_loader dut (
      .clk1      (clk1),
      .rst       (rst),
      .in_bus    (lp_if),
      .mem_we    (mem_we),
      .mem_sel   (mem_sel),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .err       (err),
      .words_wr  (words_wr)
   );

   always #5 clk1 = ~clk1;

   // Write monitor, sampled away from the active edge.
   always @(negedge clk1) begin
      if (rst && mem_we) wlog.push_back({5'd0, mem_sel, mem_addr, mem_wdata});
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] pk(input logic sel, input logic [9:0] a, input logic [15:0] d);
      return {5'd0, sel, a, d};
   endfunction

   function automatic logic [31:0] wget(input int i);
      return (i < wlog.size()) ? wlog[i] : 32'hDEAD_DEAD;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      bit ok = 1'b0;
      @(negedge clk1);
      lp_if.in_valid = 1'b1;
      lp_if.in_data  = b;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (lp_if.in_ready) begin
            @(posedge clk1);
            #1;
            lp_if.in_valid = 1'b0;
            ok = 1'b1;
         end else begin
            @(negedge clk1);
         end
      end
      if (!ok) begin
         lp_if.in_valid = 1'b0;
         check_eq("accept_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic send_txq(input int gap_max);
      for (int i = 0; i < txq.size(); i++) begin
         if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk1);
         send_byte(txq[i]);
      end
      txq.delete();
   endtask

   initial begin
      lp_if.in_valid = 1'b0;
      lp_if.in_data  = 8'h00;

      // Reset values
      repeat (3) @(negedge clk1);
      check_eq("rst_in_ready",  {31'd0, lp_if.in_ready}, 32'd0);
      check_eq("rst_mem_we",    {31'd0, mem_we},   32'd0);
      check_eq("rst_mem_sel",   {31'd0, mem_sel},  32'd0);
      check_eq("rst_mem_addr",  {22'd0, mem_addr}, 32'd0);
      check_eq("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
      check_eq("rst_cpu_hold",  {31'd0, cpu_hold}, 32'd1);
      check_eq("rst_done",      {31'd0, done},     32'd0);
      check_eq("rst_err",       {31'd0, err},      32'd0);
      check_eq("rst_words_wr",  {21'd0, words_wr}, 32'd0);
      rst = 1'b1;
      @(negedge clk1);
      check_eq("ready_after_rst", {31'd0, lp_if.in_ready}, 32'd1);

      // Instruction load: ins[5]=1234, ins[6]=ABCD, csum 0x47
      wbase = wlog.size();
      txq = '{8'hA5, 8'h00, 8'h00, 8'h05, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
      send_txq(0);
      send_byte(8'hCD);
      @(negedge clk1);
      check_eq("ins_we_latency", {31'd0, mem_we}, 32'd1);
      send_byte(8'h47);
      @(negedge clk1);
      check_eq("ins_done", {31'd0, done}, 32'd1);
      @(negedge clk1);
      check_eq("ins_done_pulse", {31'd0, done}, 32'd0);
      check_eq("ins_nwrites", wlog.size() - wbase, 32'd2);
      check_eq("ins_w0", wget(wbase),     pk(1'b0, 10'd5, 16'h1234));
      check_eq("ins_w1", wget(wbase + 1), pk(1'b0, 10'd6, 16'hABCD));
      check_eq("ins_err", {31'd0, err}, 32'd0);
      check_eq("ins_words_wr", {21'd0, words_wr}, 32'd2);
      check_eq("ins_hold", {31'd0, cpu_hold}, 32'd1);

      // Data load data[16]=002A (csum 0x3A), then RUN
      wbase = wlog.size();
      txq = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 8'h2A, 8'h3A, 8'hA5};
      send_txq(0);
      check_eq("data_nwrites", wlog.size() - wbase, 32'd1);
      check_eq("data_w0", wget(wbase), pk(1'b1, 10'd16, 16'h002A));
      check_eq("pre_run_hold", {31'd0, cpu_hold}, 32'd1);
      send_byte(8'h02);
      @(negedge clk1);
      check_eq("run_hold", {31'd0, cpu_hold}, 32'd0);
      check_eq("run_done", {31'd0, done}, 32'd1);
      check_eq("run_words_wr", {21'd0, words_wr}, 32'd3);

      // Bad checksum: writes still happen, no done, err set; MAGIC rehalts
      wbase = wlog.size();
      txq = '{8'hA5, 8'h00, 8'h00, 8'h05, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      send_txq(0);
      check_eq("bad_hold_again", {31'd0, cpu_hold}, 32'd1);
      send_byte(8'hB8);
      @(negedge clk1);
      check_eq("bad_done", {31'd0, done}, 32'd0);
      check_eq("bad_err", {31'd0, err}, 32'd1);
      check_eq("bad_nwrites", wlog.size() - wbase, 32'd2);
      send_byte(8'hA5);
      @(negedge clk1);
      check_eq("magic_clears_err", {31'd0, err}, 32'd0);
      // Unknown region code
      send_byte(8'h07);
      @(negedge clk1);
      check_eq("region_err", {31'd0, err}, 32'd1);
      check_eq("region_words_wr", {21'd0, words_wr}, 32'd5);

      // Range: data addr 622, CNT=2 -> second write suppressed, csum 0x2B
      wbase = wlog.size();
      txq = '{8'hA5, 8'h01, 8'h02, 8'h6E, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h2B};
      send_txq(0);
      @(negedge clk1);
      check_eq("range_done", {31'd0, done}, 32'd1);
      check_eq("range_err", {31'd0, err}, 32'd1);
      check_eq("range_nwrites", wlog.size() - wbase, 32'd1);
      check_eq("range_w0", wget(wbase), pk(1'b1, 10'd622, 16'h1122));
      check_eq("range_words_wr", {21'd0, words_wr}, 32'd6);

      // Gapped stream with leading garbage: same writes as the first ins load
      wbase = wlog.size();
      txq = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h05, 8'h00, 8'h02,
              8'h12, 8'h34, 8'hAB, 8'hCD, 8'h47};
      send_txq(3);
      @(negedge clk1);
      check_eq("gap_done", {31'd0, done}, 32'd1);
      check_eq("gap_err", {31'd0, err}, 32'd0);
      check_eq("gap_nwrites", wlog.size() - wbase, 32'd2);
      check_eq("gap_w0", wget(wbase),     pk(1'b0, 10'd5, 16'h1234));
      check_eq("gap_w1", wget(wbase + 1), pk(1'b0, 10'd6, 16'hABCD));
      check_eq("gap_words_wr", {21'd0, words_wr}, 32'd8);

      // Reset after DATA_H: nothing written, everything back to reset values
      txq = '{8'hA5, 8'h02};
      send_txq(0);
      wbase = wlog.size();
      txq = '{8'hA5, 8'h00, 8'h00, 8'h05, 8'h00, 8'h01, 8'h12};
      send_txq(0);
      @(negedge clk1);
      rst = 1'b0;
      #2;
      check_eq("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
      check_eq("mid_rst_we", {31'd0, mem_we}, 32'd0);
      check_eq("mid_rst_addr", {22'd0, mem_addr}, 32'd0);
      check_eq("mid_rst_words", {21'd0, words_wr}, 32'd0);
      repeat (2) @(negedge clk1);
      rst = 1'b1;
      repeat (2) @(negedge clk1);
      check_eq("mid_rst_nwrites", wlog.size() - wbase, 32'd0);

      // Fresh record after reset: data[3]=BEEF, csum 0x52
      txq = '{8'hA5, 8'h01, 8'h00, 8'h03, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h52};
      send_txq(0);
      @(negedge clk1);
      check_eq("fresh_done", {31'd0, done}, 32'd1);
      check_eq("fresh_nwrites", wlog.size() - wbase, 32'd1);
      check_eq("fresh_w0", wget(wbase), pk(1'b1, 10'd3, 16'hBEEF));
      check_eq("fresh_words_wr", {21'd0, words_wr}, 32'd1);

      // CNT=0 record goes straight to CSUM (csum 0x00)
      wbase = wlog.size();
      txq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_txq(0);
      @(negedge clk1);
      check_eq("cnt0_done", {31'd0, done}, 32'd1);
      check_eq("cnt0_err", {31'd0, err}, 32'd0);
      check_eq("cnt0_nwrites", wlog.size() - wbase, 32'd0);

      repeat (2) @(negedge clk1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
